// File: rtl/wb_pkg.sv
// Shared store-path types for the writeback store buffer and its aligner:
// size encodings, base byte-mask helper and the buffered entry layout.
package wb_pkg;

   localparam int WB_ADDR_W = 32;
   localparam int WB_DATA_W = 64;
   localparam int WB_MASK_W = WB_DATA_W / 8;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'b00,
      SZ_WORD  = 2'b01,
      SZ_DWORD = 2'b10,
      SZ_QWORD = 2'b11
   } wb_size_e;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
      logic [WB_MASK_W-1:0] mask;
   } stbuf_entry_t;

   // Byte enables for an access of the given size starting at lane 0.
   function automatic logic [7:0] size_to_mask(input logic [1:0] size);
      logic [7:0] m;
      case (size)
         SZ_BYTE:  m = 8'h01;
         SZ_WORD:  m = 8'h03;
         SZ_DWORD: m = 8'h0F;
         default:  m = 8'hFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/wb_store_align.sv
// Combinational store aligner: moves right-justified store data onto its
// byte lanes within a 64-bit doubleword and builds the matching byte mask.
// Bytes that would land beyond lane 7 are dropped; upstream never issues
// stores that cross a doubleword boundary.
module wb_store_align
   import wb_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [1:0]          size,
   input  logic [2:0]          offset,
   input  logic [DATA_W-1:0]   data,
   output logic [DATA_W-1:0]   lane_data,
   output logic [DATA_W/8-1:0] lane_mask
);

   logic [7:0] base_mask;

   // Base mask shifted to the starting lane; data shifted by whole bytes.
   always_comb begin
      base_mask = size_to_mask(size);
      lane_mask = (DATA_W/8)'(base_mask << offset);
      lane_data = data << {offset, 3'b000};
   end

endmodule

// File: rtl/wb_store_buffer.sv
// Writeback store buffer: queues aligned stores in a small circular array
// and drains them in order to the dcache over a valid/ready handshake, so
// writeback only stalls when the buffer is full.
// Optional build macro WB_STBUF_FWD_EN adds a store-to-load forwarding
// lookup (fwd_addr/fwd_hit/fwd_data/fwd_mask) over the buffered entries.
module wb_store_buffer
   import wb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                CLK,
   input  logic                CLR,
   input  logic                enq_v,
   input  logic [ADDR_W-1:0]   enq_addr,
   input  logic [DATA_W-1:0]   enq_data,
   input  logic [1:0]          enq_size,
   output logic                enq_ready,
   output logic                WB_stall,
   output logic                out_v,
   output logic [ADDR_W-1:0]   out_addr,
   output logic [DATA_W-1:0]   out_data,
   output logic [DATA_W/8-1:0] out_mask,
   input  logic                In_write_ready,
   output logic [CNT_W-1:0]    count,
   output logic                empty,
   input  logic                halt_req,
`ifdef WB_STBUF_FWD_EN
   input  logic [ADDR_W-1:0]   fwd_addr,
   output logic                fwd_hit,
   output logic [DATA_W-1:0]   fwd_data,
   output logic [DATA_W/8-1:0] fwd_mask,
`endif
   output logic                halt_ok
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Entry storage; contents need no reset since count qualifies them.
   stbuf_entry_t mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg,  count_next;

   logic               enq_fire;
   logic               deq_fire;
   logic [DATA_W-1:0]  lane_data;
   logic [DATA_W/8-1:0] lane_mask;
   stbuf_entry_t       new_entry;
   stbuf_entry_t       head_entry;
   logic [ADDR_W-1:0]  head_addr;

   wb_store_align #(.DATA_W(DATA_W)) u_align (
      .size      (enq_size),
      .offset    (enq_addr[2:0]),
      .data      (enq_data),
      .lane_data (lane_data),
      .lane_mask (lane_mask)
   );

   // Handshake status is derived from registered occupancy only, so a
   // same-cycle dequeue never opens a slot for a full buffer.
   always_comb begin
      enq_ready = (count_reg != FULL_CNT);
      out_v     = (count_reg != '0);
      enq_fire  = enq_v & enq_ready;
      deq_fire  = out_v & In_write_ready;
      WB_stall  = enq_v & ~enq_ready;
      empty     = (count_reg == '0);
      halt_ok   = halt_req & empty;
      count     = count_reg;
   end

   // Build the entry to store; the address is kept doubleword-aligned.
   always_comb begin
      new_entry.addr = WB_ADDR_W'({enq_addr[ADDR_W-1:3], 3'b000});
      new_entry.data = WB_DATA_W'(lane_data);
      new_entry.mask = WB_MASK_W'(lane_mask);
   end

   // Head entry drives the dcache side; it only moves when a dequeue fires.
   always_comb begin
      head_entry = mem[rd_ptr_reg];
      head_addr  = ADDR_W'(head_entry.addr);
      out_addr   = head_addr;
      out_data   = DATA_W'(head_entry.data);
      out_mask   = (DATA_W/8)'(head_entry.mask);
   end

   // Next-state for pointers (wrap naturally at power-of-two depth) and count.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (enq_fire) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (deq_fire) rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({enq_fire, deq_fire})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   // Pointer/count state; reset discards every queued entry at once.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Write the accepted store into the slot at the write pointer.
   always_ff @(posedge CLK) begin
      if (enq_fire) mem[wr_ptr_reg] <= new_entry;
   end

`ifdef WB_STBUF_FWD_EN
   logic [DEPTH-1:0] fwd_match;

   // One comparator per slot, qualified by whether the slot is occupied
   // (its age from the read pointer is below the current count).
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd_cmp
      logic [PTR_W-1:0]  age;
      logic [ADDR_W-1:0] slot_addr;
      assign age       = PTR_W'(gi) - rd_ptr_reg;
      assign slot_addr = ADDR_W'(mem[gi].addr);
      assign fwd_match[gi] = (CNT_W'(age) < count_reg) &&
                             (slot_addr[ADDR_W-1:3] == fwd_addr[ADDR_W-1:3]);
   end

   // Walk oldest to youngest so the youngest matching entry wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      fwd_hit  = |fwd_match;
      fwd_data = '0;
      fwd_mask = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr_reg + PTR_W'(k);
         if (fwd_match[idx]) begin
            fwd_data = DATA_W'(mem[idx].data);
            fwd_mask = (DATA_W/8)'(mem[idx].mask);
         end
      end
   end
`endif

endmodule

// File: tb/tb_wb_store_buffer.sv
// Directed bench for wb_store_buffer (DEPTH = 4).
module tb_wb_store_buffer;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 64;
   localparam int ADDR_W = 32;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic                CLK = 1'b0;
   logic                CLR = 1'b0;
   logic                enq_v = 1'b0;
   logic [ADDR_W-1:0]   enq_addr = '0;
   logic [DATA_W-1:0]   enq_data = '0;
   logic [1:0]          enq_size = '0;
   logic                enq_ready;
   logic                WB_stall;
   logic                out_v;
   logic [ADDR_W-1:0]   out_addr;
   logic [DATA_W-1:0]   out_data;
   logic [DATA_W/8-1:0] out_mask;
   logic                In_write_ready = 1'b0;
   logic [CNT_W-1:0]    count;
   logic                empty;
   logic                halt_req = 1'b0;
   logic                halt_ok;
`ifdef WB_STBUF_FWD_EN
   logic [ADDR_W-1:0]   fwd_addr = '0;
   logic                fwd_hit;
   logic [DATA_W-1:0]   fwd_data;
   logic [DATA_W/8-1:0] fwd_mask;
`endif

   int n_total = 0;
   int n_bad   = 0;

   wb_store_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .CLK            (CLK),
      .CLR            (CLR),
      .enq_v          (enq_v),
      .enq_addr       (enq_addr),
      .enq_data       (enq_data),
      .enq_size       (enq_size),
      .enq_ready      (enq_ready),
      .WB_stall       (WB_stall),
      .out_v          (out_v),
      .out_addr       (out_addr),
      .out_data       (out_data),
      .out_mask       (out_mask),
      .In_write_ready (In_write_ready),
      .count          (count),
      .empty          (empty),
      .halt_req       (halt_req),
`ifdef WB_STBUF_FWD_EN
      .fwd_addr       (fwd_addr),
      .fwd_hit        (fwd_hit),
      .fwd_data       (fwd_data),
      .fwd_mask       (fwd_mask),
`endif
      .halt_ok        (halt_ok)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Drive one store request; all vectors must stay inside one doubleword.
   task automatic put(input logic [31:0] a, input logic [1:0] sz, input logic [63:0] d);
      logic [15:0] bm;
      case (sz)
         2'b00:   bm = 16'h01;
         2'b01:   bm = 16'h03;
         2'b10:   bm = 16'h0F;
         default: bm = 16'hFF;
      endcase
      assert ((bm << a[2:0]) < 16'd256);
      enq_v    = 1'b1;
      enq_addr = a;
      enq_size = sz;
      enq_data = d;
   endtask

   initial begin
      int rx;
      int tx;
      logic [31:0] exp_addr4 [4];

      // ---- reset state ----
      #1;
      put(32'h1003, 2'b01, 64'hBEEF);
      #1;
      chk("rst_out_v", out_v, 0);
      chk("rst_enq_ready", enq_ready, 1);
      chk("rst_empty", empty, 1);
      chk("rst_wb_stall", WB_stall, 0);
      chk("rst_halt_ok", halt_ok, 0);
      chk("rst_count", count, 0);
      step();
      chk("rst_held_count", count, 0);

      // ---- single enqueue, no fall-through ----
      CLR = 1'b1;
      #1;
      chk("t1_no_fallthru", out_v, 0);
      step();
      enq_v = 1'b0;
      #1;
      chk("t1_out_v", out_v, 1);
      chk("t1_out_addr", out_addr, 64'h1000);
      chk("t1_out_mask", out_mask, 64'h18);
      chk("t1_out_data", out_data, 64'h000000BEEF000000);
      chk("t1_count", count, 1);
      In_write_ready = 1'b1;
      step();
      In_write_ready = 1'b0;
      #1;
      chk("t1_drained", empty, 1);

      // ---- fill with dcache not ready ----
      for (int i = 0; i < 4; i++) begin
         put(32'h100 + 32'(8 * i), 2'b11, 64'(i));
         step();
      end
      enq_v = 1'b0;
      #1;
      chk("t2_count_full", count, 4);
      chk("t2_enq_ready", enq_ready, 0);
      put(32'h999, 2'b00, 64'h55);
      #1;
      chk("t2_wb_stall", WB_stall, 1);
      step();
      enq_v = 1'b0;
      #1;
      chk("t2_count_kept", count, 4);
      chk("t2_head_kept", out_addr, 64'h100);

      // ---- full with simultaneous dequeue: no bypass ----
      put(32'h120, 2'b11, 64'h20);
      In_write_ready = 1'b1;
      #1;
      chk("t3_enq_ready_full", enq_ready, 0);
      chk("t3_stall_full", WB_stall, 1);
      step();
      In_write_ready = 1'b0;
      #1;
      chk("t3_count_3", count, 3);
      chk("t3_enq_ready", enq_ready, 1);
      chk("t3_head", out_addr, 64'h108);
      step();
      enq_v = 1'b0;
      #1;
      chk("t3_count_4", count, 4);
      exp_addr4[0] = 32'h108;
      exp_addr4[1] = 32'h110;
      exp_addr4[2] = 32'h118;
      exp_addr4[3] = 32'h120;
      In_write_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t3_drain_addr", out_addr, 64'(exp_addr4[i]));
         chk("t3_drain_data", out_data, (i == 3) ? 64'h20 : 64'(i + 1));
         step();
      end
      In_write_ready = 1'b0;
      #1;
      chk("t3_empty", empty, 1);

      // ---- stream of 10 with wrap, ready toggling 1010 ----
      rx = 0;
      tx = 0;
      for (int cyc = 0; cyc < 100 && rx < 10; cyc++) begin
         if (tx < 10) put(32'h4000 + 32'(8 * tx), 2'b11, 64'h0A0 + 64'(tx));
         else enq_v = 1'b0;
         In_write_ready = (cyc % 2 == 0);
         #1;
         if (out_v) begin
            chk("t4_addr", out_addr, 64'(32'h4000 + 32'(8 * rx)));
            chk("t4_data", out_data, 64'h0A0 + 64'(rx));
            chk("t4_mask", out_mask, 64'hFF);
            if (In_write_ready) rx++;
         end
         if (enq_v && enq_ready) tx++;
         step();
      end
      enq_v = 1'b0;
      In_write_ready = 1'b0;
      #1;
      chk("t4_received", 64'(rx), 64'd10);
      chk("t4_empty", empty, 1);

      // ---- halt drain ----
      put(32'h500, 2'b11, 64'h1);
      step();
      put(32'h508, 2'b11, 64'h2);
      step();
      enq_v = 1'b0;
      halt_req = 1'b1;
      #1;
      chk("t5_halt_2", halt_ok, 0);
      In_write_ready = 1'b1;
      step();
      chk("t5_halt_1", halt_ok, 0);
      chk("t5_count_1", count, 1);
      step();
      chk("t5_halt_0", halt_ok, 1);
      chk("t5_enq_ready_halt", enq_ready, 1);
      halt_req = 1'b0;
      In_write_ready = 1'b0;

      // ---- asynchronous reset mid-drain ----
      for (int i = 0; i < 3; i++) begin
         put(32'h600 + 32'(8 * i), 2'b11, 64'(i));
         step();
      end
      enq_v = 1'b0;
      In_write_ready = 1'b1;
      step();
      #1;
      chk("t6_count_pre", count, 2);
      CLR = 1'b0;
      #1;
      chk("t6_clr_count", count, 0);
      chk("t6_clr_out_v", out_v, 0);
      chk("t6_clr_empty", empty, 1);
      step();
      CLR = 1'b1;
      In_write_ready = 1'b0;
      #1;
      chk("t6_after_out_v", out_v, 0);

`ifdef WB_STBUF_FWD_EN
      // ---- forwarding ----
      put(32'h2000, 2'b11, 64'h1111111111111111);
      fwd_addr = 32'h2000;
      #1;
      chk("f_same_cycle_hit", fwd_hit, 0);
      step();
      put(32'h2004, 2'b10, 64'hAA);
      fwd_addr = 32'h2006;
      #1;
      chk("f_old_hit", fwd_hit, 1);
      chk("f_old_mask", fwd_mask, 64'hFF);
      step();
      enq_v = 1'b0;
      #1;
      chk("f_hit", fwd_hit, 1);
      chk("f_mask", fwd_mask, 64'hF0);
      chk("f_data", fwd_data, 64'h000000AA00000000);
      fwd_addr = 32'h3000;
      #1;
      chk("f_miss", fwd_hit, 0);
      In_write_ready = 1'b1;
      step();
      step();
      In_write_ready = 1'b0;
      #1;
      chk("f_empty", empty, 1);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
